// File: rtl/alu_bist_misr_analyzer.sv
// Response analyzer for the execute-stage ALU BIST: compacts ALU result/carry into a MISR,
// checks the end-of-session signature and latches the sticky spare-ALU select after repeated fails.
module alu_bist_misr_analyzer #(
    parameter int               WIDTH          = 32,
    parameter int               NUM_VECTORS    = 8,
    parameter int               CNT_W          = 3,
    parameter logic [WIDTH-1:0] POLY           = 32'h04C11DB7,
    parameter logic [WIDTH-1:0] SEED           = 32'hFFFFFFFF,
    parameter logic [WIDTH-1:0] GOLDEN_SIG     = 32'h00000000,
    parameter int               FAIL_THRESHOLD = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             test_en,
    input  logic [CNT_W-1:0] test_counter,
    input  logic [WIDTH-1:0] primary_res,
    input  logic             primary_carry,
    input  logic             clear_fault,
    output logic             session_done,
    output logic             session_pass,
    output logic             session_abort,
    output logic [1:0]       fail_count,
    output logic [WIDTH-1:0] signature,
    output logic             fault_detected,
    output logic             mux_sel
);

    typedef enum logic [1:0] {IDLE, ACCUM, EVAL, FAULT} state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VECTORS - 1);
    localparam logic [1:0]       THRESH   = 2'(FAIL_THRESHOLD);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] exp_idx, idx_nxt;
    logic [WIDTH-1:0] sig_nxt;
    logic [1:0]       fail_base, fail_inc, fail_nxt;
    logic             done_nxt, pass_nxt, abort_nxt, fault_nxt;

    function automatic logic [WIDTH-1:0] misr_step(input logic [WIDTH-1:0] s,
                                                   input logic [WIDTH-1:0] res,
                                                   input logic             carry);
        return {s[WIDTH-2:0], 1'b0} ^ (s[WIDTH-1] ? POLY : '0) ^ res ^ {{(WIDTH-1){1'b0}}, carry};
    endfunction

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'd3) ? c : c + 2'd1;
    endfunction

    // clear_fault outside FAULT only zeroes the count; a session in flight keeps going
    assign fail_base = clear_fault ? 2'd0 : fail_count;
    assign fail_inc  = sat_inc(fail_base);

    always_comb begin
        state_nxt = state;
        sig_nxt   = signature;
        idx_nxt   = exp_idx;
        fail_nxt  = fail_base;
        done_nxt  = 1'b0;
        pass_nxt  = 1'b0;
        abort_nxt = 1'b0;
        fault_nxt = fault_detected;
        case (state)
            IDLE: begin
                if (test_en && test_counter == '0) begin
                    sig_nxt   = misr_step(SEED, primary_res, primary_carry);
                    idx_nxt   = CNT_W'(1);
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                if (!test_en) begin
                    abort_nxt = 1'b1;
                    state_nxt = IDLE;
                end else if (test_counter != exp_idx) begin
                    abort_nxt = 1'b1;
                    fail_nxt  = fail_inc;
                    state_nxt = IDLE;
                end else begin
                    sig_nxt = misr_step(signature, primary_res, primary_carry);
                    idx_nxt = exp_idx + 1'b1;
                    if (exp_idx == LAST_IDX) state_nxt = EVAL;
                end
            end
            EVAL: begin
                // test_en is not looked at here, so a counter=0 arriving now is dropped
                done_nxt = 1'b1;
                pass_nxt = (signature == GOLDEN_SIG);
                if (pass_nxt) begin
                    fail_nxt  = 2'd0;
                    state_nxt = IDLE;
                end else begin
                    fail_nxt = fail_inc;
                    if (fail_inc >= THRESH) begin
                        fault_nxt = 1'b1;
                        state_nxt = FAULT;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            FAULT: begin
                if (clear_fault) begin
                    fault_nxt = 1'b0;
                    sig_nxt   = SEED;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            signature      <= SEED;
            exp_idx        <= '0;
            fail_count     <= 2'd0;
            session_done   <= 1'b0;
            session_pass   <= 1'b0;
            session_abort  <= 1'b0;
            fault_detected <= 1'b0;
        end else begin
            state          <= state_nxt;
            signature      <= sig_nxt;
            exp_idx        <= idx_nxt;
            fail_count     <= fail_nxt;
            session_done   <= done_nxt;
            session_pass   <= pass_nxt;
            session_abort  <= abort_nxt;
            fault_detected <= fault_nxt;
        end
    end

    assign mux_sel = fault_detected;

endmodule
